int_to_fp32_pipe: RTL and testbench
===================================

// Module: int_to_fp32_pipe
// PURPOSE
//  Parametrised, pipelined integer-to-IEEE-754-binary32 converter; successor to the
//  combinational int_to_fp32. Adds configurable input width, per-transaction
//  signed/unsigned and rounding-mode selection, an inexact flag, a sideband tag and a
//  valid/ready handshake with backpressure. Feeds the FP32 datapath (fp_multiplier
//  operands) from integer sources.
// PARAMETERS
//  INT_W  32  input integer width, legal 8..64 (magnitude always < FP32 max)
//  TAG_W  4   sideband tag width, passed through unchanged, >=1
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      input transaction valid
//  in_ready   out  1      converter accepts input this cycle
//  in_data    in   INT_W  integer operand
//  in_signed  in   1      1: in_data is two's complement; 0: unsigned
//  in_rnd     in   1      0: round-to-nearest-even (RNE); 1: round-toward-zero (RTZ)
//  in_tag     in   TAG_W  sideband tag
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  result     out  32     FP32 result {sign, exp[7:0], man[22:0]}
//  out_tag    out  TAG_W  tag of this result
//  Inexact    out  1      rounding discarded nonzero bits
//  Overflow   out  1      constant 0 for legal INT_W; kept for family interface
//  Underflow  out  1      constant 0 (integers never subnormal)
//  Exception  out  1      = Overflow | Underflow
// BEHAVIOUR
//  - Reset (async, rst_n=0): all stage valid bits, out_valid, result, out_tag and flags
//    -> 0. in_ready is 1 as soon as reset releases. Reset mid-operation discards all
//    in-flight transactions; no output follows for them.
//  - Pipeline: 3 registered stages, S1 capture, S2 normalise, S3 round/pack.
//    Latency 3 cycles from accepted input to out_valid; throughput 1 per cycle.
//  - Handshake: adv = !out_valid | out_ready; in_ready = adv. All stages shift together
//    on adv (bubbles travel with the pipe). Transfer on in_valid&in_ready; output
//    consumed on out_valid&out_ready. While out_valid&!out_ready, result, flags and
//    out_tag hold stable. No transaction is lost, duplicated or reordered.
//  - S1: sign = in_signed & in_data[INT_W-1]; mag = sign ? -in_data : in_data as an
//    INT_W-bit unsigned (signed INT_MIN -> 2^(INT_W-1), fits). Latch rnd, tag.
//  - S2: lz = leading zeros of mag; norm = mag << lz (MSB at bit INT_W-1);
//    e = INT_W-1-lz; zero = (mag==0).
//  - S3: frac = norm[INT_W-2 -: 23], zero-padded below when INT_W<24;
//    guard = next bit; sticky = OR of all lower bits (0 if none).
//    RNE: inc = guard & (sticky | frac[0]); RTZ: inc = 0.
//    {c,man} = frac + inc; exp = 127 + e + c (c=1 gives man=0, exponent +1).
//    Inexact = guard | sticky. zero -> result 0x00000000 (never -0), Inexact 0.
//  - INT_W<=24: every conversion exact, Inexact always 0.
//  - in_signed/in_rnd are sampled per transaction; changing them between
//    transactions never affects in-flight results.
// STRUCTURE
//  - int_fp_pkg: FP32_EXP_W=8, FP32_MAN_W=23, FP32_BIAS=127, RND_RNE=1'b0,
//    RND_RTZ=1'b1; shared with fp_multiplier.
//  - Sub-module lzc #(.W(INT_W)): combinational leading-zero counter,
//    out width $clog2(W+1), output W for all-zero input. Used in S2.
//  - Everything else inline: stage registers, shifter, rounder, handshake.
// TESTING (INT_W=32)
//  1. 0, signed/RNE -> 0x00000000, Inexact 0; -5 signed -> 0xC0A00000; 1 -> 0x3F800000.
//  2. 16777219: RNE -> 0x4B800002 (tie to even), RTZ -> 0x4B800001, Inexact 1 both;
//     16777216 -> 0x4B800000, Inexact 0.
//  3. 0x7FFFFFFF signed: RNE -> 0x4F000000 (carry into exponent), RTZ -> 0x4EFFFFFF.
//  4. 0x80000000: signed -> 0xCF000000 exact; unsigned -> 0x4F000000;
//     0xFFFFFFFF unsigned RNE -> 0x4F800000; signed -> 0xBF800000.
//  5. Back-to-back 6 inputs, tags 0..5, out_ready low cycles 4-8 -> first out_valid at
//     cycle 3, in_ready low while stalled, outputs stable, all 6 in order, no loss.
//  6. rst_n low for 1 cycle with 3 in flight -> out_valid 0 immediately, none emerge;
//     next input after reset appears 3 cycles later. Repeat 1-4 at INT_W=16 and 64.

Source files
------------

// File: rtl/int_fp_pkg.sv
// -----------------------------------------------------------------------------
// int_fp_pkg
//   Shared FP32 constants, rounding-mode encodings and a packing helper for the
//   integer-to-FP32 converter and the rest of the FP32 datapath
//   (fp_multiplier uses the same definitions).
//
//   Contents:
//     FP32_EXP_W / FP32_MAN_W / FP32_BIAS : binary32 field widths and bias
//     RND_RNE / RND_RTZ                   : per-transaction rounding select codes
//     fp32_t                              : {sign, exp, man} packed view
//     fp32_pack()                         : assemble an fp32_t from its fields
// -----------------------------------------------------------------------------
package int_fp_pkg;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP32_BIAS  = 127;

    // Rounding-mode select, sampled with each transaction.
    localparam logic RND_RNE = 1'b0;  // round to nearest, ties to even
    localparam logic RND_RTZ = 1'b1;  // round toward zero (truncate)

    typedef struct packed {
        logic                  sign;
        logic [FP32_EXP_W-1:0] exp;
        logic [FP32_MAN_W-1:0] man;
    } fp32_t;

    function automatic fp32_t fp32_pack(
        input logic                  sign,
        input logic [FP32_EXP_W-1:0] exp,
        input logic [FP32_MAN_W-1:0] man
    );
        fp32_t f;
        f.sign = sign;
        f.exp  = exp;
        f.man  = man;
        return f;
    endfunction

endpackage : int_fp_pkg

// File: rtl/lzc.sv
// -----------------------------------------------------------------------------
// lzc
//   Combinational leading-zero counter. Counts zeros above the most significant
//   set bit of i_data; an all-zero input reports W.
//
//   Parameters:
//     W    input width (>= 1)
//   Ports:
//     i_data  in   W             value to scan
//     o_cnt   out  $clog2(W+1)   number of leading zeros (W when i_data == 0)
// -----------------------------------------------------------------------------
module lzc #(
    parameter int W = 32
) (
    input  logic [W-1:0]           i_data,
    output logic [$clog2(W+1)-1:0] o_cnt
);

    localparam int CW = $clog2(W+1);

    // Ascending scan: the last set bit visited is the most significant one,
    // so its position wins.
    always_comb begin
        // NOTE: o_cnt gets a default before the loop so no path leaves it
        // unassigned; without it the conditional writes would infer a latch.
        o_cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (i_data[i]) begin
                o_cnt = CW'(W - 1 - i);
            end
        end
    end

endmodule : lzc

// File: rtl/int_to_fp32_pipe.sv
// -----------------------------------------------------------------------------
// int_to_fp32_pipe
//   Three-stage pipelined integer to IEEE-754 binary32 converter with a
//   valid/ready handshake. Each transaction carries its own signedness,
//   rounding mode and sideband tag.
//
//     S1 capture  : sign extraction and magnitude (two's-complement negate)
//     S2 normalise: leading-zero count, left shift, unbiased exponent
//     S3 round    : RNE/RTZ rounding, exponent carry, pack, inexact flag
//
//   All stages advance together whenever the output register is empty or is
//   being consumed (adv = !out_valid | out_ready); bubbles travel with the pipe.
//
//   Parameters:
//     INT_W  input integer width, 8..64
//     TAG_W  sideband tag width, >= 1
//   Ports:
//     clk, rst_n          rising-edge clock, asynchronous active-low reset
//     in_valid/in_ready   input handshake (in_ready = adv)
//     in_data             integer operand
//     in_signed           1: two's complement, 0: unsigned
//     in_rnd              RND_RNE / RND_RTZ
//     in_tag              sideband tag, returned unchanged on out_tag
//     out_valid/out_ready output handshake; result/out_tag/flags hold while stalled
//     result              FP32 {sign, exp[7:0], man[22:0]}
//     Inexact             rounding discarded nonzero bits
//     Overflow/Underflow  constant 0 for legal INT_W (family interface)
//     Exception           Overflow | Underflow
// -----------------------------------------------------------------------------
module int_to_fp32_pipe
    import int_fp_pkg::*;
#(
    parameter int INT_W = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INT_W-1:0] in_data,
    input  logic             in_signed,
    input  logic             in_rnd,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic [TAG_W-1:0] out_tag,
    output logic             Inexact,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Exception
);

    localparam int LZ_W = $clog2(INT_W + 1);
    // Bits of the normalised value below its leading one, padded with enough
    // zeros that a 23-bit fraction plus guard always exist even for INT_W < 24.
    localparam int EXT_W = (INT_W - 1) + (FP32_MAN_W + 1);

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic w_adv;
    logic w_take;

    assign w_adv    = !out_valid | out_ready;
    assign in_ready = w_adv;
    assign w_take   = in_valid & w_adv;

    // -------------------------------------------------------------------------
    // S1: sign and magnitude
    // -------------------------------------------------------------------------
    logic             w_s1_sign;
    logic [INT_W-1:0] w_s1_mag;

    assign w_s1_sign = in_signed & in_data[INT_W-1];
    // INT_MIN negates to 2^(INT_W-1), which is representable as unsigned.
    assign w_s1_mag  = w_s1_sign ? (~in_data + INT_W'(1)) : in_data;

    logic             r_s1_valid;
    logic             r_s1_sign;
    logic [INT_W-1:0] r_s1_mag;
    logic             r_s1_rnd;
    logic [TAG_W-1:0] r_s1_tag;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous cycle's values of the stage before it.
    // NOTE: payload registers are reset along with the valid bits so the
    // pipeline holds no X after reset; they load only under a valid token.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_mag   <= '0;
            r_s1_rnd   <= RND_RNE;
            r_s1_tag   <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_take;
            if (w_take) begin
                r_s1_sign <= w_s1_sign;
                r_s1_mag  <= w_s1_mag;
                r_s1_rnd  <= in_rnd;
                r_s1_tag  <= in_tag;
            end
        end
    end

    // -------------------------------------------------------------------------
    // S2: normalise
    // -------------------------------------------------------------------------
    logic [LZ_W-1:0]       w_lz;
    logic [INT_W-1:0]      w_norm;
    logic [FP32_EXP_W-1:0] w_e;

    lzc #(.W(INT_W)) u_lzc (
        .i_data (r_s1_mag),
        .o_cnt  (w_lz)
    );

    assign w_norm = r_s1_mag << w_lz;
    // Unbiased exponent; meaningless for a zero magnitude, which S3 overrides.
    assign w_e    = FP32_EXP_W'(INT_W - 1) - FP32_EXP_W'(w_lz);

    logic                  r_s2_valid;
    logic                  r_s2_sign;
    logic                  r_s2_zero;
    logic [INT_W-2:0]      r_s2_norm;   // bits below the leading one
    logic [FP32_EXP_W-1:0] r_s2_e;
    logic                  r_s2_rnd;
    logic [TAG_W-1:0]      r_s2_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_zero  <= 1'b0;
            r_s2_norm  <= '0;
            r_s2_e     <= '0;
            r_s2_rnd   <= RND_RNE;
            r_s2_tag   <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign <= r_s1_sign;
                // After normalisation the MSB is clear only for a zero input.
                r_s2_zero <= ~w_norm[INT_W-1];
                r_s2_norm <= w_norm[INT_W-2:0];
                r_s2_e    <= w_e;
                r_s2_rnd  <= r_s1_rnd;
                r_s2_tag  <= r_s1_tag;
            end
        end
    end

    // -------------------------------------------------------------------------
    // S3: round and pack
    // -------------------------------------------------------------------------
    logic [EXT_W-1:0]      w_ext;
    logic [FP32_MAN_W-1:0] w_frac;
    logic                  w_guard;
    logic                  w_sticky;
    logic                  w_inc;
    logic                  w_carry;
    logic [FP32_MAN_W-1:0] w_man;
    logic [FP32_EXP_W-1:0] w_exp;
    logic                  w_inexact;
    fp32_t                 w_res;

    assign w_ext    = {r_s2_norm, {(FP32_MAN_W + 1){1'b0}}};
    assign w_frac   = w_ext[EXT_W-1 -: FP32_MAN_W];
    assign w_guard  = w_ext[INT_W-1];
    assign w_sticky = |w_ext[INT_W-2:0];

    // Ties (guard set, sticky clear) round up only when the fraction is odd.
    assign w_inc = (r_s2_rnd == RND_RNE) & w_guard & (w_sticky | w_frac[0]);

    // A carry out of the fraction leaves man = 0 and bumps the exponent,
    // which is exactly the next power of two.
    assign {w_carry, w_man} = {1'b0, w_frac} + {{FP32_MAN_W{1'b0}}, w_inc};
    assign w_exp = FP32_EXP_W'(FP32_BIAS) + r_s2_e + {{(FP32_EXP_W-1){1'b0}}, w_carry};

    assign w_inexact = (w_guard | w_sticky) & ~r_s2_zero;
    // Zero always packs as +0, never -0.
    assign w_res = r_s2_zero ? fp32_t'('0) : fp32_pack(r_s2_sign, w_exp, w_man);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            out_tag   <= '0;
            Inexact   <= 1'b0;
        end else if (w_adv) begin
            out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                result  <= w_res;
                out_tag <= r_s2_tag;
                Inexact <= w_inexact;
            end
        end
    end

    // Integer magnitudes below 2^64 never overflow binary32 and are never
    // subnormal.
    assign Overflow  = 1'b0;
    assign Underflow = 1'b0;
    assign Exception = Overflow | Underflow;

endmodule : int_to_fp32_pipe

// File: tb/tb_int_to_fp32_pipe.sv
// -----------------------------------------------------------------------------
// tb_int_to_fp32_pipe
//   Directed bench for int_to_fp32_pipe. Three instances (INT_W = 32, 16, 64)
//   share clock, reset and handshake inputs and run the same vector table in
//   lockstep; expected results are hand-computed constants. The 32-bit
//   instance is also exercised for backpressure and mid-flight reset.
// -----------------------------------------------------------------------------
module tb_int_to_fp32_pipe;

    logic clk;
    logic rst_n;

    logic        in_valid;
    logic        in_signed;
    logic        in_rnd;
    logic [3:0]  in_tag;
    logic        out_ready;
    logic [31:0] d32;
    logic [15:0] d16;
    logic [63:0] d64;

    logic        ir32, ir16, ir64;
    logic        ov32, ov16, ov64;
    logic [31:0] r32, r16, r64;
    logic [3:0]  t32, t16, t64;
    logic        x32, x16, x64;
    logic        of32, of16, of64;
    logic        uf32, uf16, uf64;
    logic        ex32, ex16, ex64;

    int n_total = 0;
    int n_bad   = 0;

    int_to_fp32_pipe #(.INT_W(32), .TAG_W(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
        .in_data(d32), .in_signed(in_signed), .in_rnd(in_rnd), .in_tag(in_tag),
        .out_valid(ov32), .out_ready(out_ready), .result(r32), .out_tag(t32),
        .Inexact(x32), .Overflow(of32), .Underflow(uf32), .Exception(ex32)
    );

    int_to_fp32_pipe #(.INT_W(16), .TAG_W(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16),
        .in_data(d16), .in_signed(in_signed), .in_rnd(in_rnd), .in_tag(in_tag),
        .out_valid(ov16), .out_ready(out_ready), .result(r16), .out_tag(t16),
        .Inexact(x16), .Overflow(of16), .Underflow(uf16), .Exception(ex16)
    );

    int_to_fp32_pipe #(.INT_W(64), .TAG_W(4)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir64),
        .in_data(d64), .in_signed(in_signed), .in_rnd(in_rnd), .in_tag(in_tag),
        .out_valid(ov64), .out_ready(out_ready), .result(r64), .out_tag(t64),
        .Inexact(x64), .Overflow(of64), .Underflow(uf64), .Exception(ex64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One directed vector per row, applied to all three widths at once.
    typedef struct {
        logic        s;
        logic        rnd;
        logic [31:0] d32; logic [31:0] e32; logic x32;
        logic [15:0] d16; logic [31:0] e16; logic x16;
        logic [63:0] d64; logic [31:0] e64; logic x64;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin
        //            s     rnd   d32           e32           x     d16       e16           x     d64                     e64           x
        vecs[0]  = '{1'b1, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 16'h0000, 32'h00000000, 1'b0, 64'h0000000000000000, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'hFFFFFFFB, 32'hC0A00000, 1'b0, 16'hFFFB, 32'hC0A00000, 1'b0, 64'hFFFFFFFFFFFFFFFB, 32'hC0A00000, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h00000001, 32'h3F800000, 1'b0, 16'h0001, 32'h3F800000, 1'b0, 64'h0000000000000001, 32'h3F800000, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 32'h01000003, 32'h4B800002, 1'b1, 16'h7FFF, 32'h46FFFE00, 1'b0, 64'h0000000001000003, 32'h4B800002, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 32'h01000003, 32'h4B800001, 1'b1, 16'h7FFF, 32'h46FFFE00, 1'b0, 64'h0000000001000003, 32'h4B800001, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 32'h01000000, 32'h4B800000, 1'b0, 16'h0100, 32'h43800000, 1'b0, 64'h0000000001000000, 32'h4B800000, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h4F000000, 1'b1, 16'h7FFF, 32'h46FFFE00, 1'b0, 64'h7FFFFFFFFFFFFFFF, 32'h5F000000, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 32'h7FFFFFFF, 32'h4EFFFFFF, 1'b1, 16'h7FFF, 32'h46FFFE00, 1'b0, 64'h7FFFFFFFFFFFFFFF, 32'h5EFFFFFF, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'h80000000, 32'hCF000000, 1'b0, 16'h8000, 32'hC7000000, 1'b0, 64'h8000000000000000, 32'hDF000000, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h80000000, 32'h4F000000, 1'b0, 16'h8000, 32'h47000000, 1'b0, 64'h8000000000000000, 32'h5F000000, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h4F800000, 1'b1, 16'hFFFF, 32'h477FFF00, 1'b0, 64'hFFFFFFFFFFFFFFFF, 32'h5F800000, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hBF800000, 1'b0, 16'hFFFF, 32'hBF800000, 1'b0, 64'hFFFFFFFFFFFFFFFF, 32'hBF800000, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 32'h01000001, 32'h4B800000, 1'b1, 16'h0003, 32'h40400000, 1'b0, 64'h0000000001000001, 32'h4B800000, 1'b1};
    end

    // Present one vector for one cycle, wait for the result (bounded) and
    // compare all three widths. Entered and left at posedge+1.
    task automatic run_vec(input int i);
        int lat;
        in_valid  = 1'b1;
        in_signed = vecs[i].s;
        in_rnd    = vecs[i].rnd;
        in_tag    = 4'(i);
        d32       = vecs[i].d32;
        d16       = vecs[i].d16;
        d64       = vecs[i].d64;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (ov32) begin
                lat = n;
                break;
            end
        end
        check($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
        check($sformatf("v%0d_valid16", i), 64'(ov16), 64'd1);
        check($sformatf("v%0d_valid64", i), 64'(ov64), 64'd1);
        check($sformatf("v%0d_res32", i), 64'(r32), 64'(vecs[i].e32));
        check($sformatf("v%0d_inx32", i), 64'(x32), 64'(vecs[i].x32));
        check($sformatf("v%0d_tag32", i), 64'(t32), 64'(i));
        check($sformatf("v%0d_res16", i), 64'(r16), 64'(vecs[i].e16));
        check($sformatf("v%0d_inx16", i), 64'(x16), 64'(vecs[i].x16));
        check($sformatf("v%0d_res64", i), 64'(r64), 64'(vecs[i].e64));
        check($sformatf("v%0d_inx64", i), 64'(x64), 64'(vecs[i].x64));
        @(posedge clk); #1;
    endtask

    // Expected results for the backpressure burst: inputs 1..6 unsigned.
    logic [31:0] bp_exp [6];

    initial begin
        int          idx;
        int          ocnt;
        int          first;
        logic        prev_stall;
        logic [31:0] prev_res;
        logic [3:0]  prev_tag;
        logic        acc;
        logic        seen;

        bp_exp[0] = 32'h3F800000;
        bp_exp[1] = 32'h40000000;
        bp_exp[2] = 32'h40400000;
        bp_exp[3] = 32'h40800000;
        bp_exp[4] = 32'h40A00000;
        bp_exp[5] = 32'h40C00000;

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        in_rnd    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        d32 = '0; d16 = '0; d64 = '0;

        // ---------------- reset state ----------------
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(ov32), 64'd0);
        check("rst_result",    64'(r32),  64'd0);
        check("rst_out_tag",   64'(t32),  64'd0);
        check("rst_inexact",   64'(x32),  64'd0);
        check("rst_in_ready",  64'(ir32), 64'd1);
        check("rst_valid16_64", 64'({ov16, ov64}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("post_rst_in_ready", 64'(ir32), 64'd1);
        check("flags_32", 64'({of32, uf32, ex32}), 64'd0);
        check("flags_16", 64'({of16, uf16, ex16}), 64'd0);
        check("flags_64", 64'({of64, uf64, ex64}), 64'd0);
        @(posedge clk); #1;

        // ---------------- directed vectors ----------------
        for (int i = 0; i < NV; i++) begin
            run_vec(i);
        end

        // ---------------- backpressure burst ----------------
        idx = 0; ocnt = 0; first = -1;
        prev_stall = 1'b0; prev_res = '0; prev_tag = '0;
        in_signed = 1'b0;
        in_rnd    = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            in_valid  = (idx < 6);
            d32       = 32'(idx + 1);
            d16       = 16'(idx + 1);
            d64       = 64'(idx + 1);
            in_tag    = 4'(idx);
            out_ready = !(cyc >= 4 && cyc <= 8);
            @(negedge clk);
            if (prev_stall) begin
                check($sformatf("bp_hold_valid_c%0d", cyc), 64'(ov32), 64'd1);
                check($sformatf("bp_hold_res_c%0d", cyc),   64'(r32),  64'(prev_res));
                check($sformatf("bp_hold_tag_c%0d", cyc),   64'(t32),  64'(prev_tag));
            end
            if (cyc >= 4 && cyc <= 8) begin
                check($sformatf("bp_in_ready_c%0d", cyc), 64'(ir32), 64'd0);
            end
            if (ov32 && first < 0) first = cyc;
            if (ov32 && out_ready) begin
                if (ocnt < 6) begin
                    check($sformatf("bp_res_%0d", ocnt), 64'(r32), 64'(bp_exp[ocnt]));
                    check($sformatf("bp_tag_%0d", ocnt), 64'(t32), 64'(ocnt));
                end
                ocnt++;
            end
            prev_stall = ov32 && !out_ready;
            prev_res   = r32;
            prev_tag   = t32;
            acc        = in_valid && ir32;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_first_valid_cycle", 64'(first), 64'd3);
        check("bp_outputs_seen",      64'(ocnt),  64'd6);
        check("bp_inputs_taken",      64'(idx),   64'd6);

        // ---------------- reset with transactions in flight ----------------
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            d32 = 32'(k + 7); d16 = 16'(k + 7); d64 = 64'(k + 7);
            in_tag = 4'(k + 8);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", 64'(ov32), 64'd0);
        check("midrst_result",    64'(r32),  64'd0);
        check("midrst_tag",       64'(t32),  64'd0);
        check("midrst_in_ready",  64'(ir32), 64'd1);
        check("midrst_valid16_64", 64'({ov16, ov64}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (ov32 || ov16 || ov64) seen = 1'b1;
        end
        check("midrst_none_emerge", 64'(seen), 64'd0);
        @(posedge clk); #1;
        run_vec(2);
        run_vec(8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_int_to_fp32_pipe
